// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a valid/ready byte port feeds a small FIFO,
// and a baud-timed shifter drains it as back-to-back frames on serial_out.
module uart_tx_buffered #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int BW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      shift_q, shift_d;
  logic            serial_q, serial_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic full;
  logic push;
  logic pop;
  logic baud_tc;

  // Handshake: a byte transfers on any rising edge where data_in_valid and
  // data_in_ready are both high; ready depends only on registered FIFO state.
  assign full          = (count_q == CW'(FIFO_DEPTH));
  assign push          = data_in_valid && !full;
  assign baud_tc       = (baud_q == BW'(SYMBOL_EDGE_TIME - 1));

  assign data_in_ready = !full;
  assign serial_out    = serial_q;
  assign fifo_count    = count_q;
  assign busy          = (state_q == SEND) || (count_q != '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = {1'b1, mem_q[rd_ptr_q], 1'b0};
          baud_d  = '0;
          bit_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            // Chain the next frame straight off the stop bit when data waits.
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = {1'b1, mem_q[rd_ptr_q], 1'b0};
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = {1'b1, shift_q[9:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    serial_d = (state_d == SEND) ? shift_d[0] : 1'b1;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      serial_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a line decoder feeding a scoreboard.
module tb_uart_tx_buffered;

  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int FIFO_DEPTH = 8;
  localparam int SET        = CLOCK_FREQ / BAUD_RATE;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data_in = 8'h00;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic          serial_out;
  logic [CW-1:0] fifo_count;
  logic          busy;

  uart_tx_buffered #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .fifo_count   (fifo_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int sb_idx = 0;
  logic [7:0] exp_q[$];

  // Host-side line decoder, sampling at bit centres on falling clock edges.
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         rx_neg = 0;
  int         rx_cnt = 0;
  int         rx_frame_err = 0;
  logic       rx_active = 1'b0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    int k;
    rx_neg <= rx_neg + 1;
    if (rst) begin
      rx_active <= 1'b0;
    end else if (!rx_active) begin
      if (serial_out == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
        rx_start_q.push_back(rx_neg);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if ((rx_cnt % SET) == SET / 2) begin
        k = rx_cnt / SET;
        if (k == 0) begin
          if (serial_out != 1'b0) rx_active <= 1'b0;
        end else if (k <= 8) begin
          rx_sh[k-1] <= serial_out;
        end else begin
          if (serial_out != 1'b1) rx_frame_err <= rx_frame_err + 1;
          rx_q.push_back(rx_sh);
          rx_active <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_rx();
    check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = sb_idx; i < exp_q.size(); i++)
      check("rx_byte", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hdead, 32'(exp_q[i]));
    sb_idx = exp_q.size();
    check("rx_frame_err", 32'(rx_frame_err), 32'd0);
  endtask

  logic [9:0] exp_bits = 10'b1011000010;  // 0x61 framed, start bit at [0]
  logic [7:0] b;
  int         base;
  int         accepted;
  int         guard;

  initial begin
    // Reset held for 10 cycles
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_serial", 32'(serial_out), 32'd1);
    check("rst_ready", 32'(data_in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);

    // Single byte 0x61: latency, bit pattern, frame length
    @(posedge clk); #1 data_in = 8'h61; data_in_valid = 1'b1;
    exp_q.push_back(8'h61);
    @(posedge clk); #1 data_in_valid = 1'b0;
    check("single_count_n", 32'(fifo_count), 32'd1);
    check("single_busy_n", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_idle_before_pop", 32'(serial_out), 32'd1);
    @(negedge clk);
    check("single_start_low", 32'(serial_out), 32'd0);
    check("single_count_pop", 32'(fifo_count), 32'd0);
    repeat (SET / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("single_bit", 32'(serial_out), 32'(exp_bits[k]));
      if (k < 9) repeat (SET) @(negedge clk);
    end
    repeat (SET / 2 - 1) @(negedge clk);
    check("single_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_serial_end", 32'(serial_out), 32'd1);
    check_rx();

    // Back-to-back 0d 0a 31 with no idle gap
    base = rx_start_q.size();
    @(posedge clk); #1 data_in = 8'h0d; data_in_valid = 1'b1;
    @(posedge clk); #1 data_in = 8'h0a;
    @(posedge clk); #1 data_in = 8'h31;
    @(posedge clk); #1 data_in_valid = 1'b0;
    exp_q.push_back(8'h0d); exp_q.push_back(8'h0a); exp_q.push_back(8'h31);
    wait_idle(40 * SET);
    check("b2b_gap1", (rx_start_q.size() > base + 1) ?
          32'(rx_start_q[base+1] - rx_start_q[base]) : 32'hdead, 32'(10 * SET));
    check("b2b_gap2", (rx_start_q.size() > base + 2) ?
          32'(rx_start_q[base+2] - rx_start_q[base+1]) : 32'hdead, 32'(10 * SET));
    check_rx();

    // Fill: bytes 0..9 offered on consecutive edges, only 0..8 fit
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 data_in = 8'(i); data_in_valid = 1'b1;
      @(negedge clk);
      check("full_ready", 32'(data_in_ready), (i < 9) ? 32'd1 : 32'd0);
      if (i < 9) exp_q.push_back(8'(i));
    end
    @(posedge clk); #1 data_in_valid = 1'b0;
    check("full_ready_after", 32'(data_in_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd8);
    wait_idle(12 * 10 * SET);
    check_rx();

    // Asynchronous reset during bit 4 of 0x55 with 0xaa queued
    @(posedge clk); #1 data_in = 8'h55; data_in_valid = 1'b1;
    @(posedge clk); #1 data_in = 8'haa;
    @(posedge clk); #1 data_in_valid = 1'b0;
    repeat (4 * SET + SET / 2) @(posedge clk);
    #2;
    check("midrst_bit4_low", 32'(serial_out), 32'd0);
    check("midrst_count_pre", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_serial", 32'(serial_out), 32'd1);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(data_in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 data_in = 8'h3e; data_in_valid = 1'b1;
    exp_q.push_back(8'h3e);
    @(posedge clk); #1 data_in_valid = 1'b0;
    wait_idle(12 * SET);
    check_rx();

    // Random valid stalls against ready for 32 bytes
    accepted = 0;
    guard = 0;
    b = 8'($urandom_range(0, 255));
    while (accepted < 32 && guard < 20000) begin
      @(posedge clk); #1 data_in = b; data_in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (data_in_valid && data_in_ready) begin
        exp_q.push_back(b);
        accepted++;
        b = 8'($urandom_range(0, 255));
      end
      guard++;
    end
    @(posedge clk); #1 data_in_valid = 1'b0;
    check("stall_accepted", 32'(accepted), 32'd32);
    wait_idle(40 * 10 * SET);
    check_rx();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
